data_packer: RTL and testbench

//  Parametrised narrow-to-wide packer: accepts IN_W-bit beats over valid/ready and

---
 rtl/data_packer_pkg.sv | 41 ++++
 rtl/data_packer_if.sv | 35 +++
 rtl/data_packer_fifo.sv | 83 ++++++++
 rtl/data_packer.sv | 96 +++++++++
 tb/tb_data_packer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_packer_pkg.sv
// pack_pkg: shared widths, helpers and the FIFO entry layout for the data_packer slice.
// Width helpers are functions so parametrised modules can size themselves from
// their own N / FIFO_DEPTH; the localparams and pack_entry_t describe the default
// 8-bit-in / 256-bit-out / 2-deep configuration.
package pack_pkg;

  localparam int unsigned DEF_IN_W       = 8;
  localparam int unsigned DEF_OUT_W      = 256;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned DEF_N          = DEF_OUT_W / DEF_IN_W;

  localparam int unsigned LANE_W = $clog2(DEF_N);
  localparam int unsigned CNT_W  = $clog2(DEF_N + 1);
  localparam int unsigned PTR_W  = $clog2(DEF_FIFO_DEPTH);

  typedef struct packed {
    logic [DEF_OUT_W-1:0] data;
    logic [CNT_W-1:0]     cnt;
    logic                 last;
  } pack_entry_t;

  // Lane counter width; N >= 2 so $clog2 never returns 0 in practice.
  function automatic int unsigned lane_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lane-count field width: must hold the value N itself.
  function automatic int unsigned cnt_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned ptr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Physical lane for the cnt-th beat of a word.
  function automatic int unsigned lane_idx(int unsigned cnt, int unsigned n, bit msb_first);
    return msb_first ? (n - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/data_packer_if.sv
// data_packer_if: input beat stream and output word stream of the packer.
//   in_valid/in_ready/in_data/in_last         : narrow beat handshake
//   out_valid/out_ready/out_data/out_cnt/out_last : wide word handshake
// master = the surrounding system (beat source and word sink),
// slave  = the packer itself.
interface data_packer_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 256
);

  localparam int unsigned N   = OUT_W / IN_W;
  localparam int unsigned OCW = pack_pkg::cnt_w(N);

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            in_last;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [OCW-1:0]   out_cnt;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_last
  );

endinterface

// File: rtl/data_packer_fifo.sv
// pack_fifo: synchronous FIFO of DEPTH entries of W bits with a registered head.
//   clk_i, rst_i (async, active-high)
//   push_i/push_data_i : write request (ignored while full)
//   pop_i              : consume head (ignored while empty)
//   head_o             : current head entry, zero when empty
//   valid_o            : FIFO not empty (registered)
//   full_o             : FIFO full (registered)
module pack_fifo
  import pack_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic         full_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          empty_q, full_q;
  logic          push, pop;

  assign push = push_i && !full_q;
  assign pop  = pop_i && !empty_q;

  // The head register always mirrors the entry at the next read pointer so the
  // output fields come straight from a flop. A push into an empty FIFO (or a
  // push while the only entry is popped) bypasses memory into the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    head_d   = head_q;
    if (count_d == '0) begin
      head_d = '0;
    end else if (pop) begin
      head_d = (count_q == CW'(1)) ? push_data_i : mem_q[rd_ptr_d];
    end else if (count_q == '0) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = head_q;
  assign valid_o = !empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/data_packer.sv
// data_packer: packs IN_W-bit beats into OUT_W-bit words (N = OUT_W/IN_W lanes).
//   sys_clk  : single clock, all logic on posedge
//   sys_rst  : async, active-high reset
//   bus      : data_packer_if slave modport
//     in_valid/in_ready/in_data/in_last : beat input; in_last closes a partial word
//     out_valid/out_ready/out_data/out_cnt/out_last : FIFO head; unfilled lanes zero,
//       out_cnt = filled lanes (1..N), out_last = word closed by in_last
// MSB_FIRST=0 places the first beat in lane 0, MSB_FIRST=1 in lane N-1.
module data_packer
  import pack_pkg::*;
#(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned OUT_W      = 256,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  data_packer_if.slave bus
);

  localparam int unsigned N   = OUT_W / IN_W;
  localparam int unsigned LW  = lane_w(N);
  localparam int unsigned OCW = cnt_w(N);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [OCW-1:0]   cnt;
    logic             last;
  } entry_t;

  logic [LW-1:0]    lane_cnt_q, lane_cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] beat_word;
  logic             beat;
  logic             close;
  entry_t           push_entry;
  entry_t           head_entry;
  logic             fifo_full;
  logic             fifo_valid;

  // in_ready comes from the registered full flag, so nothing here depends
  // combinationally on out_ready.
  assign bus.in_ready = !fifo_full;

  always_comb begin
    beat      = bus.in_valid && !fifo_full;
    beat_word = {{(OUT_W-IN_W){1'b0}}, bus.in_data}
                << (IN_W * lane_idx(32'(lane_cnt_q), N, MSB_FIRST));
    close     = beat && ((lane_cnt_q == LW'(N - 1)) || bus.in_last);

    push_entry.data = acc_q | beat_word;
    push_entry.cnt  = OCW'(lane_cnt_q) + OCW'(1);
    push_entry.last = bus.in_last;

    lane_cnt_d = lane_cnt_q;
    acc_d      = acc_q;
    if (close) begin
      lane_cnt_d = '0;
      acc_d      = '0;
    end else if (beat) begin
      lane_cnt_d = lane_cnt_q + LW'(1);
      acc_d      = push_entry.data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lane_cnt_q <= '0;
      acc_q      <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      acc_q      <= acc_d;
    end
  end

  pack_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .push_i      (close),
    .push_data_i (push_entry),
    .pop_i       (bus.out_ready),
    .head_o      (head_entry),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = head_entry.data;
  assign bus.out_cnt   = head_entry.cnt;
  assign bus.out_last  = head_entry.last;

endmodule

// File: tb/tb_data_packer.sv
module tb_data_packer;

  localparam int unsigned IW = 8;
  localparam int unsigned OW = 256;
  localparam int unsigned NL = OW / IW;

  typedef struct {
    logic [OW-1:0] data;
    int unsigned   cnt;
    bit            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_packer_if #(.IN_W(IW), .OUT_W(OW)) ifa ();
  data_packer_if #(.IN_W(IW), .OUT_W(OW)) ifb ();

  data_packer #(.IN_W(IW), .OUT_W(OW), .FIFO_DEPTH(2), .MSB_FIRST(1'b0)) dut_a (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (ifa)
  );

  data_packer #(.IN_W(IW), .OUT_W(OW), .FIFO_DEPTH(2), .MSB_FIRST(1'b1)) dut_b (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (ifb)
  );

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [OW-1:0] acc_m [2];
  int unsigned   lane_m [2];
  exp_t          ea, eb;

  // Scoreboard: a word is compared whenever a DUT hands it over.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL mon_a: unexpected word cnt=%0d last=%0b, required no word", ifa.out_cnt, ifa.out_last);
        end else begin
          ea = q_a.pop_front();
          checks++;
          if (ifa.out_data !== ea.data || 32'(ifa.out_cnt) !== ea.cnt || ifa.out_last !== ea.last) begin
            errors++;
            $display("FAIL mon_a: got data=%h cnt=%0d last=%0b, required data=%h cnt=%0d last=%0b",
                     ifa.out_data, ifa.out_cnt, ifa.out_last, ea.data, ea.cnt, ea.last);
          end
        end
      end
      if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL mon_b: unexpected word cnt=%0d last=%0b, required no word", ifb.out_cnt, ifb.out_last);
        end else begin
          eb = q_b.pop_front();
          checks++;
          if (ifb.out_data !== eb.data || 32'(ifb.out_cnt) !== eb.cnt || ifb.out_last !== eb.last) begin
            errors++;
            $display("FAIL mon_b: got data=%h cnt=%0d last=%0b, required data=%h cnt=%0d last=%0b",
                     ifb.out_data, ifb.out_cnt, ifb.out_last, eb.data, eb.cnt, eb.last);
          end
        end
      end
    end
  end

  task automatic model_accept(input bit sel, input logic [7:0] d, input bit last);
    int unsigned   pos;
    logic [OW-1:0] w;
    exp_t          e;
    pos = sel ? (NL - 1 - lane_m[sel]) : lane_m[sel];
    w = '0;
    w[pos*8 +: 8] = d;
    acc_m[sel] = acc_m[sel] | w;
    if (lane_m[sel] == NL - 1 || last) begin
      e.data = acc_m[sel];
      e.cnt  = lane_m[sel] + 1;
      e.last = last;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
      acc_m[sel]  = '0;
      lane_m[sel] = 0;
    end else begin
      lane_m[sel] = lane_m[sel] + 1;
    end
  endtask

  task automatic set_in(input bit sel, input bit v, input logic [7:0] d, input bit l);
    if (sel) begin
      ifb.in_valid = v; ifb.in_data = d; ifb.in_last = l;
    end else begin
      ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l;
    end
  endtask

  // Called and returns at posedge+1; leaves in_valid asserted for back-to-back use.
  task automatic send_beat(input bit sel, input logic [7:0] d, input bit l);
    bit rdy;
    bit done;
    done = 1'b0;
    set_in(sel, 1'b1, d, l);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      rdy = sel ? ifb.in_ready : ifa.in_ready;
      if (!rdy) stalls++;
      @(posedge clk); #1;
      if (rdy) begin
        model_accept(sel, d, l);
        done = 1'b1;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL send_beat: beat %h not accepted within 400 cycles, required acceptance", d);
    end
  endtask

  task automatic wait_valid(input bit sel, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? ifb.out_valid : ifa.out_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: out_valid not seen within 50 cycles, required 1", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    acc_m[0] = '0; acc_m[1] = '0; lane_m[0] = 0; lane_m[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", ifa.out_valid); end
    checks++; if (ifa.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h, required 0", ifa.out_data); end
    checks++; if (ifa.out_cnt !== '0) begin errors++; $display("FAIL rst_out_cnt: got %0d, required 0", ifa.out_cnt); end
    checks++; if (ifa.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b, required 0", ifa.out_last); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", ifa.in_ready); end
    checks++; if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_b: got %b, required 1", ifb.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 31; k++) send_beat(1'b0, 8'(k), 1'b0);
    checks++;
    if (ifa.out_valid !== 1'b0) begin
      errors++; $display("FAIL full_early: out_valid=%b before beat 31, required 0", ifa.out_valid);
    end
    send_beat(1'b0, 8'h1F, 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (ifa.out_valid !== 1'b1 || ifa.out_cnt !== 6'd32) begin
      errors++; $display("FAIL full_latency: out_valid=%b cnt=%0d one cycle after beat 31, required 1 and 32",
                         ifa.out_valid, ifa.out_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_last();
    logic [OW-1:0] w;
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(1'b0, 8'hA1 + 8'(i), i == 4);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    wait_valid(1'b0, "partial_valid");
    w = ifa.out_data;
    checks++; if (ifa.out_cnt !== 6'd5) begin errors++; $display("FAIL partial_cnt: got %0d, required 5", ifa.out_cnt); end
    checks++; if (w[39:0] !== 40'hA5A4A3A2A1) begin errors++; $display("FAIL partial_lanes: got %h, required a5a4a3a2a1", w[39:0]); end
    checks++; if (w[255:40] !== '0) begin errors++; $display("FAIL partial_zero: got %h, required 0", w[255:40]); end
    checks++; if (ifa.out_last !== 1'b1) begin errors++; $display("FAIL partial_last: got %b, required 1", ifa.out_last); end
    @(posedge clk); #1;
    ifa.out_ready = 1'b1;
    send_beat(1'b0, 8'h5A, 1'b1);
    for (int k = 0; k < 32; k++) send_beat(1'b0, 8'hC0 ^ 8'(k), k == 31);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ifa.out_valid !== 1'b0 || q_a.size() != 0) begin
      errors++; $display("FAIL last_on_full: out_valid=%b pending=%0d after lane N-1 last, required 0 and 0",
                         ifa.out_valid, q_a.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    logic [OW-1:0] w;
    ifb.out_ready = 1'b0;
    send_beat(1'b1, 8'h11, 1'b0);
    send_beat(1'b1, 8'h22, 1'b1);
    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    wait_valid(1'b1, "msb_valid");
    w = ifb.out_data;
    checks++; if (w[255:248] !== 8'h11) begin errors++; $display("FAIL msb_lane_top: got %h, required 11", w[255:248]); end
    checks++; if (w[247:240] !== 8'h22) begin errors++; $display("FAIL msb_lane_next: got %h, required 22", w[247:240]); end
    checks++; if (w[239:0] !== '0) begin errors++; $display("FAIL msb_rest: got %h, required 0", w[239:0]); end
    checks++; if (ifb.out_cnt !== 6'd2) begin errors++; $display("FAIL msb_cnt: got %0d, required 2", ifb.out_cnt); end
    repeat (3) @(negedge clk);
    checks++;
    if (ifb.out_valid !== 1'b1 || ifb.out_data !== w || ifb.out_cnt !== 6'd2 || ifb.out_last !== 1'b1) begin
      errors++; $display("FAIL head_stable: valid=%b data=%h cnt=%0d last=%b, required 1 %h 2 1",
                         ifb.out_valid, ifb.out_data, ifb.out_cnt, ifb.out_last, w);
    end
    @(posedge clk); #1;
    ifb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 32; k++) send_beat(1'b0, 8'h40 + 8'(k), 1'b0);
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_one_word: in_ready=%b with one word queued, required 1", ifa.in_ready);
    end
    for (int k = 0; k < 32; k++) send_beat(1'b0, 8'h60 + 8'(k), 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (ifa.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: in_ready=%b after second word, required 0", ifa.in_ready);
    end
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 32; k++) send_beat(1'b0, 8'h80 + 8'(k), 1'b0);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
      end
      begin
        repeat (10) @(negedge clk);
        checks++;
        if (ifa.in_ready !== 1'b0 || q_a.size() != 2 || lane_m[0] != 0) begin
          errors++; $display("FAIL bp_stall: in_ready=%b queued=%0d lanes=%0d while full, required 0 2 0",
                             ifa.in_ready, q_a.size(), lane_m[0]);
        end
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || ifa.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: pending=%0d out_valid=%b after release, required 0 0", q_a.size(), ifa.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int gaps;
    gaps = 0;
    ifa.out_ready = 1'b1;
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send_beat(1'b0, 8'h30 + 8'(i), 1'b1);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
      end
      begin
        @(negedge clk);
        for (int j = 0; j < 16; j++) begin
          @(negedge clk);
          if (ifa.out_valid !== 1'b1) gaps++;
        end
      end
    join
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_ready: %0d stall cycles, required 0", stalls); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_valid: %0d cycles without out_valid, required 0", gaps); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 32; k++) send_beat(1'b0, 8'hD0 ^ 8'(k), 1'b0);
    for (int k = 0; k < 10; k++) send_beat(1'b0, 8'hE0 + 8'(k), 1'b0);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, required 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b, required 1", ifa.in_ready); end
    checks++; if (ifa.out_cnt !== '0) begin errors++; $display("FAIL rmid_cnt: got %0d, required 0", ifa.out_cnt); end
    q_a.delete();
    acc_m[0]  = '0;
    lane_m[0] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    send_beat(1'b0, 8'hF1, 1'b0);
    send_beat(1'b0, 8'hF2, 1'b1);
    set_in(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_last();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL end_queue_a: %0d words never produced, required 0", q_a.size()); end
    checks++;
    if (q_b.size() != 0) begin errors++; $display("FAIL end_queue_b: %0d words never produced, required 0", q_b.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
